// File: rtl/reduce_combine.sv
// reduce_combine: receiving end of the reduce-instruction path.
// Flits tagged with a children count are folded into a small table keyed by
// {contextId, tag}; once the local and all child contributions have arrived a
// single 73-bit result flit is emitted toward the root.
// Optional build macro REDUCE_TIMEOUT_EN adds per-entry idle counters that
// flush a stale partial result (op field forced to 4'hF) after TimeoutCycles.
//
// Handshake: a flit on packetIn moves on a rising edge where packetIn[72] and
// inReady are both high; packetOut moves where packetOut[72] and outReady are
// both high. packetOut holds steady while not taken, and inReady never depends
// on packetIn[72].
module reduce_combine #(
  parameter logic [2:0] rank_x        = 3'b000,
  parameter logic [2:0] rank_y        = 3'b000,
  parameter logic [2:0] rank_z        = 3'b000,
  parameter int         FlitWidth     = 73,
  parameter int         ChildrenPos   = 73,
  parameter int         ChildrenWidth = 3,
  parameter int         TableSize     = 4,
  parameter int         TimeoutCycles = 255
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ChildrenPos+ChildrenWidth-1:0] packetIn,
  output logic                                 inReady,
  output logic [FlitWidth-1:0]                 packetOut,
  input  logic                                 outReady
);

  localparam int IW = (TableSize > 1) ? $clog2(TableSize) : 1;
  localparam int VB = FlitWidth - 1;

  // input field split
  logic [ChildrenWidth-1:0] w_children;
  logic                     w_in_valid;
  logic [7:0]               w_ctx;
  logic [7:0]               w_tag;
  logic [3:0]               w_op;
  logic [1:0]               w_alg;
  logic [8:0]               w_dst;
  logic [31:0]              w_payload;
  logic [8:0]               w_src;

  assign w_children = packetIn[ChildrenPos +: ChildrenWidth];
  assign w_in_valid = packetIn[72];
  assign w_dst      = packetIn[71:63];
  assign w_ctx      = packetIn[53:46];
  assign w_tag      = packetIn[45:38];
  assign w_alg      = packetIn[37:36];
  assign w_op       = packetIn[35:32];
  assign w_payload  = packetIn[31:0];
  assign w_src      = {rank_z, rank_y, rank_x};

  // reduction table
  logic [TableSize-1:0] r_valid;
  logic [7:0]           r_ctx [TableSize];
  logic [7:0]           r_tag [TableSize];
  logic [3:0]           r_op  [TableSize];
  logic [1:0]           r_alg [TableSize];
  logic [8:0]           r_dst [TableSize];
  logic [31:0]          r_acc [TableSize];
  logic [3:0]           r_rem [TableSize];

  logic [FlitWidth-1:0] r_out;

  logic          w_hit;
  logic [IW-1:0] w_hit_idx;
  logic          w_free;
  logic [IW-1:0] w_free_idx;
  logic          w_leaf;
  logic          w_stall;
  logic          w_accept;
  logic          w_upd_hit;
  logic          w_hit_last;
  logic          w_emit_leaf;
  logic          w_emit_hit;
  logic          w_alloc;
  logic          w_to_fire;
  logic [IW-1:0] w_to_idx;
  logic [31:0]   w_acc_new;
  logic          w_load;
  logic [FlitWidth-1:0] w_next_flit;

  // fold one payload into an accumulator; unknown ops behave as add
  function automatic logic [31:0] f_combine(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    case (op)
      4'd1:    r = (a > b) ? a : b;
      4'd2:    r = (a < b) ? a : b;
      4'd3:    r = a & b;
      4'd4:    r = a | b;
      4'd5:    r = a ^ b;
      default: r = a + b;
    endcase
    return r;
  endfunction

  // key match against valid entries (at most one entry can hold a key)
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < TableSize; i++) begin
      if (r_valid[i] && (r_ctx[i] == w_ctx) && (r_tag[i] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_idx = IW'(i);
      end
    end
  end

  // lowest-index free entry for allocation
  always_comb begin
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = TableSize - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free     = 1'b1;
        w_free_idx = IW'(i);
      end
    end
  end

  assign w_leaf      = (w_children == '0);
  assign w_stall     = r_out[VB] & ~outReady;
  assign inReady     = ~rst & ~w_stall & (w_hit | w_leaf | w_free);
  assign w_accept    = w_in_valid & inReady;
  // a leaf never touches the table, even if its key is in flight
  assign w_upd_hit   = w_accept & ~w_leaf & w_hit;
  assign w_hit_last  = (r_rem[w_hit_idx] == 4'd1);
  assign w_emit_leaf = w_accept & w_leaf;
  assign w_emit_hit  = w_upd_hit & w_hit_last;
  assign w_alloc     = w_accept & ~w_leaf & ~w_hit;
  // stored op wins over the op carried by the arriving flit
  assign w_acc_new   = f_combine(r_op[w_hit_idx], r_acc[w_hit_idx], w_payload);

`ifdef REDUCE_TIMEOUT_EN
  logic [7:0] r_idle [TableSize];
  logic       w_to_any;

  // pick the lowest stale entry not being touched by an accept this cycle
  always_comb begin
    w_to_any = 1'b0;
    w_to_idx = '0;
    for (int i = TableSize - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_idle[i] == 8'(TimeoutCycles)) &&
          !(w_upd_hit && (w_hit_idx == IW'(i)))) begin
        w_to_any = 1'b1;
        w_to_idx = IW'(i);
      end
    end
  end

  assign w_to_fire = w_to_any & ~w_stall & ~w_emit_leaf & ~w_emit_hit;

  logic w_unused_fields;
  assign w_unused_fields = ^packetIn[62:54];
`else
  assign w_to_fire = 1'b0;
  assign w_to_idx  = '0;

  logic w_unused_fields;
  assign w_unused_fields = ^{packetIn[62:54], (TimeoutCycles != 0)};
`endif

  // select the flit to load into the output register; accepts beat flushes
  always_comb begin
    w_load      = 1'b0;
    w_next_flit = '0;
    if (w_emit_leaf) begin
      w_load      = 1'b1;
      w_next_flit = {1'b1, w_dst, w_src, packetIn[53:0]};
    end else if (w_emit_hit) begin
      w_load      = 1'b1;
      w_next_flit = {1'b1, r_dst[w_hit_idx], w_src, r_ctx[w_hit_idx],
                     r_tag[w_hit_idx], r_alg[w_hit_idx], r_op[w_hit_idx],
                     w_acc_new};
    end else if (w_to_fire) begin
      w_load      = 1'b1;
      w_next_flit = {1'b1, r_dst[w_to_idx], w_src, r_ctx[w_to_idx],
                     r_tag[w_to_idx], r_alg[w_to_idx], 4'hF, r_acc[w_to_idx]};
    end
  end

  // output register and table state update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_valid <= '0;
    end else begin
      if (w_load) begin
        r_out <= w_next_flit;
      end else if (r_out[VB] && outReady) begin
        r_out <= '0;
      end

      for (int i = 0; i < TableSize; i++) begin
`ifdef REDUCE_TIMEOUT_EN
        if (r_valid[i] && (r_idle[i] != 8'(TimeoutCycles))) begin
          r_idle[i] <= r_idle[i] + 8'd1;
        end
`endif
        if (w_to_fire && (w_to_idx == IW'(i))) begin
          r_valid[i] <= 1'b0;
        end
        if (w_upd_hit && (w_hit_idx == IW'(i))) begin
          if (w_hit_last) begin
            r_valid[i] <= 1'b0;
          end else begin
            r_acc[i] <= w_acc_new;
            r_rem[i] <= r_rem[i] - 4'd1;
          end
`ifdef REDUCE_TIMEOUT_EN
          r_idle[i] <= 8'd0;
`endif
        end
        if (w_alloc && (w_free_idx == IW'(i))) begin
          r_valid[i] <= 1'b1;
          r_ctx[i]   <= w_ctx;
          r_tag[i]   <= w_tag;
          r_op[i]    <= w_op;
          r_alg[i]   <= w_alg;
          r_dst[i]   <= w_dst;
          r_acc[i]   <= w_payload;
          r_rem[i]   <= 4'(w_children);
`ifdef REDUCE_TIMEOUT_EN
          r_idle[i]  <= 8'd0;
`endif
        end
      end
    end
  end

  assign packetOut = r_out;

endmodule
